// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, ALU select encodings, FSM states and the control word shared by the decode unit.
//   No ports. The control word carries every registered control flag.
package decode_pkg;

    localparam int unsigned LOADI = 0;
    localparam int unsigned MOVE  = 1;
    localparam int unsigned ADD   = 2;
    localparam int unsigned SUB   = 3;
    localparam int unsigned AND   = 4;
    localparam int unsigned OR    = 5;
    localparam int unsigned JUMP  = 6;
    localparam int unsigned BEQ   = 7;
    localparam int unsigned BNE   = 11;
    localparam int unsigned SRL   = 12;
    localparam int unsigned SLL   = 13;
    localparam int unsigned SRA   = 14;
    localparam int unsigned ROR   = 15;
    localparam int unsigned LWD   = 16;
    localparam int unsigned LWI   = 17;
    localparam int unsigned SWD   = 18;
    localparam int unsigned SWI   = 19;

    localparam logic [2:0] ALU_FWD = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SHL = 3'd5;
    localparam logic [2:0] ALU_SRA = 3'd6;
    localparam logic [2:0] ALU_ROR = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT} state_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic       is_sub;
        logic       is_imm;
        logic       we;
        logic       is_jump;
        logic       is_branch;
        logic       is_bne;
        logic       is_shl;
        logic       is_mem;
        logic       mem_read;
        logic       mem_write;
    } ctrl_t;

    // Common ALU-style word; every flag not named here is zero.
    function automatic ctrl_t alu_ctrl(input logic [2:0] aluop, input logic sub, input logic imm, input logic we);
        ctrl_t c;
        c        = '0;
        c.aluop  = aluop;
        c.is_sub = sub;
        c.is_imm = imm;
        c.we     = we;
        return c;
    endfunction

endpackage

// File: rtl/decode_control_seq_if.sv
// decode_control_seq_if: fetch/decode/datapath signal bundle for decode_control_seq.
//   master: fetch side (drives instruction, instr_valid, busywait; receives decoded fields/controls).
//   slave : decoder side (the reverse).
interface decode_control_seq_if #(
    parameter int INSTR_W    = 32,
    parameter int FIELD_W    = 8,
    parameter int REG_ADDR_W = 3,
    parameter int ALUOP_W    = 3
);
    logic [INSTR_W-1:0]    instruction;
    logic                  instr_valid;
    logic                  busywait;
    logic [REG_ADDR_W-1:0] source1;
    logic [REG_ADDR_W-1:0] source2;
    logic [REG_ADDR_W-1:0] destination;
    logic [FIELD_W-1:0]    immediate_value;
    logic [FIELD_W-1:0]    jump_value;
    logic [ALUOP_W-1:0]    alu_op;
    logic                  is_sub;
    logic                  is_immediate;
    logic                  write_enable;
    logic                  is_jump;
    logic                  is_branch;
    logic                  is_bne;
    logic                  is_shift_left;
    logic                  is_mem;
    logic                  mem_read;
    logic                  mem_write;
    logic                  illegal;
    logic                  pc_stall;
    logic                  instr_accept;

    modport master (
        output instruction, instr_valid, busywait,
        input  source1, source2, destination, immediate_value, jump_value, alu_op,
               is_sub, is_immediate, write_enable, is_jump, is_branch, is_bne,
               is_shift_left, is_mem, mem_read, mem_write, illegal, pc_stall, instr_accept
    );

    modport slave (
        input  instruction, instr_valid, busywait,
        output source1, source2, destination, immediate_value, jump_value, alu_op,
               is_sub, is_immediate, write_enable, is_jump, is_branch, is_bne,
               is_shift_left, is_mem, mem_read, mem_write, illegal, pc_stall, instr_accept
    );
endinterface

// File: rtl/decode_control_lut.sv
// decode_control_lut: combinational opcode to control-word lookup.
//   opcode  in  OPCODE_W  instruction opcode field
//   ctrl    out ctrl_t    control word (all zero for undefined opcodes)
//   illegal out 1         opcode is undefined
module decode_control_lut import decode_pkg::*; #(
    parameter int OPCODE_W = 8
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                illegal
);
    logic [31:0] op;

    always_comb begin
        op      = 32'(opcode);
        ctrl    = '0;
        illegal = 1'b0;
        case (op)
            LOADI: ctrl = alu_ctrl(ALU_FWD, 1'b0, 1'b1, 1'b1);
            MOVE:  ctrl = alu_ctrl(ALU_FWD, 1'b0, 1'b0, 1'b1);
            ADD:   ctrl = alu_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b1);
            SUB:   ctrl = alu_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b1);
            AND:   ctrl = alu_ctrl(ALU_AND, 1'b0, 1'b0, 1'b1);
            OR:    ctrl = alu_ctrl(ALU_OR,  1'b0, 1'b0, 1'b1);
            JUMP:  ctrl.is_jump = 1'b1;
            BEQ: begin
                ctrl           = alu_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b0);
                ctrl.is_branch = 1'b1;
            end
            BNE: begin
                ctrl        = alu_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b0);
                ctrl.is_bne = 1'b1;
            end
            SRL:   ctrl = alu_ctrl(ALU_SHL, 1'b0, 1'b1, 1'b1);
            SLL: begin
                ctrl        = alu_ctrl(ALU_SHL, 1'b0, 1'b1, 1'b1);
                ctrl.is_shl = 1'b1;
            end
            SRA:   ctrl = alu_ctrl(ALU_SRA, 1'b0, 1'b1, 1'b1);
            ROR:   ctrl = alu_ctrl(ALU_ROR, 1'b0, 1'b1, 1'b1);
            LWD: begin
                ctrl          = alu_ctrl(ALU_FWD, 1'b0, 1'b0, 1'b1);
                ctrl.is_mem   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            LWI: begin
                ctrl          = alu_ctrl(ALU_FWD, 1'b0, 1'b1, 1'b1);
                ctrl.is_mem   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            SWD: begin
                ctrl           = alu_ctrl(ALU_FWD, 1'b0, 1'b0, 1'b0);
                ctrl.is_mem    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            SWI: begin
                ctrl           = alu_ctrl(ALU_FWD, 1'b0, 1'b1, 1'b0);
                ctrl.is_mem    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/decode_control_seq.sv
// decode_control_seq: registered instruction decode with valid handshake and data-memory stall FSM.
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   bus   slave modport of decode_control_seq_if (instruction/valid/busywait in, decoded fields and controls out)
//   instr_count, stall_count out 16 (only when DECODE_PERF_EN is defined): saturating accept / MEM_WAIT cycle counters
module decode_control_seq import decode_pkg::*; #(
    parameter int INSTR_W    = 32,
    parameter int OPCODE_W   = 8,
    parameter int FIELD_W    = 8,
    parameter int REG_ADDR_W = 3,
    parameter int ALUOP_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_control_seq_if.slave  bus
`ifdef DECODE_PERF_EN
    ,
    output logic [15:0]          instr_count,
    output logic [15:0]          stall_count
`endif
);
    state_t                state, state_n;
    ctrl_t                 ctrl_d, ctrl_q;
    logic                  illegal_d, illegal_q;
    logic                  accept;
    logic [FIELD_W-1:0]    des, s1, s2;
    logic [REG_ADDR_W-1:0] dst_q, s1_q, s2_q;
    logic [FIELD_W-1:0]    imm_q, jmp_q;
    logic                  unused_s1;

    assign des       = bus.instruction[3*FIELD_W-1 -: FIELD_W];
    assign s1        = bus.instruction[2*FIELD_W-1 -: FIELD_W];
    assign s2        = bus.instruction[FIELD_W-1:0];
    // Only the register-address bits of S1 have a consumer.
    assign unused_s1 = ^s1[FIELD_W-1:REG_ADDR_W];

    decode_control_lut #(.OPCODE_W(OPCODE_W)) u_lut (
        .opcode  (bus.instruction[INSTR_W-1 -: OPCODE_W]),
        .ctrl    (ctrl_d),
        .illegal (illegal_d)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_comb begin
        accept           = bus.instr_valid && state != MEM_WAIT;
        state_n          = state == MEM_WAIT ? (bus.busywait ? MEM_WAIT : IDLE)
                         : !accept           ? IDLE
                         : ctrl_d.is_mem     ? MEM_WAIT : RUN;
        bus.instr_accept = accept;
        bus.pc_stall     = state == MEM_WAIT || state_n == MEM_WAIT;
    end

    // Fields survive the drop to IDLE; controls do not. Completing a memory
    // op retires only the memory/write-back flags, the rest are held.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            dst_q     <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            imm_q     <= '0;
            jmp_q     <= '0;
        end else if (accept) begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            dst_q     <= des[REG_ADDR_W-1:0];
            s1_q      <= s1[REG_ADDR_W-1:0];
            s2_q      <= s2[REG_ADDR_W-1:0];
            imm_q     <= s2;
            jmp_q     <= des;
        end else if (state == MEM_WAIT) begin
            if (!bus.busywait) begin
                ctrl_q.mem_read  <= 1'b0;
                ctrl_q.mem_write <= 1'b0;
                ctrl_q.is_mem    <= 1'b0;
                ctrl_q.we        <= 1'b0;
            end
        end else begin
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end

    assign bus.destination     = dst_q;
    assign bus.source1         = s1_q;
    assign bus.source2         = s2_q;
    assign bus.immediate_value = imm_q;
    assign bus.jump_value      = jmp_q;
    assign bus.alu_op          = ALUOP_W'(ctrl_q.aluop);
    assign bus.is_sub          = ctrl_q.is_sub;
    assign bus.is_immediate    = ctrl_q.is_imm;
    assign bus.write_enable    = ctrl_q.we;
    assign bus.is_jump         = ctrl_q.is_jump;
    assign bus.is_branch       = ctrl_q.is_branch;
    assign bus.is_bne          = ctrl_q.is_bne;
    assign bus.is_shift_left   = ctrl_q.is_shl;
    assign bus.is_mem          = ctrl_q.is_mem;
    assign bus.mem_read        = ctrl_q.mem_read;
    assign bus.mem_write       = ctrl_q.mem_write;
    assign bus.illegal         = illegal_q;

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            if (accept && instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            if (state == MEM_WAIT && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
`endif
endmodule

// File: tb/tb_decode_control_seq.sv
// tb_decode_control_seq: directed-vector scoreboard bench for decode_control_seq.
module tb_decode_control_seq;
    typedef struct packed {
        logic [2:0] dst, s1, s2;
        logic [7:0] imm, jmp;
        logic [2:0] alu;
        logic [9:0] fl;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0, n_err = 0, n_acc = 0, exp_stall = 0;
    bit   pend = 1'b0;
    exp_t exp_q[$];

    decode_control_seq_if bus();
`ifdef DECODE_PERF_EN
    logic [15:0] instr_count, stall_count;
`endif

    decode_control_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DECODE_PERF_EN
        ,
        .instr_count (instr_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] ins, input logic [2:0] alu, input logic [9:0] fl, input logic ill);
        exp_t e;
        e.dst = ins[18:16];
        e.s1  = ins[10:8];
        e.s2  = ins[2:0];
        e.imm = ins[7:0];
        e.jmp = ins[23:16];
        e.alu = alu;
        e.fl  = fl;
        e.ill = ill;
        return e;
    endfunction

    // flag order: sub imm we jump branch bne shl mem rd wr
    function automatic exp_t act();
        exp_t e;
        e.dst = bus.destination;
        e.s1  = bus.source1;
        e.s2  = bus.source2;
        e.imm = bus.immediate_value;
        e.jmp = bus.jump_value;
        e.alu = bus.alu_op;
        e.fl  = {bus.is_sub, bus.is_immediate, bus.write_enable, bus.is_jump, bus.is_branch,
                 bus.is_bne, bus.is_shift_left, bus.is_mem, bus.mem_read, bus.mem_write};
        e.ill = bus.illegal;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [2:0] alu, input logic [9:0] fl, input logic ill);
        bus.instruction = ins;
        bus.instr_valid = 1'b1;
        exp_q.push_back(mk(ins, alu, fl, ill));
        n_acc++;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [2:0] alu, input logic [9:0] fl, input logic ill);
        drive(ins, alu, fl, ill);
        step();
    endtask

    task automatic issue_mem(input logic [31:0] ins, input logic [9:0] fl, input int nbusy);
        exp_t e;
        e = mk(ins, 3'd0, fl, 1'b0);
        drive(ins, 3'd0, fl, 1'b0);
        #1 chk("pcstall_on_accept", bus.pc_stall, 1);
        step();
        for (int i = 0; i < nbusy; i++) begin
            bus.instruction = 32'h02070707;
            bus.instr_valid = 1'b1;
            bus.busywait    = 1'b1;
            #1;
            chk("memwait_pcstall", bus.pc_stall, 1);
            chk("memwait_no_accept", bus.instr_accept, 0);
            chk("memwait_hold", act(), e);
            step();
        end
        bus.busywait    = 1'b0;
        bus.instr_valid = 1'b0;
        #1 chk("memwait_last_pcstall", bus.pc_stall, 1);
        step();
        #1;
        e.fl = e.fl & 10'b1101111000;
        chk("mem_complete", act(), e);
        chk("mem_complete_pcstall", bus.pc_stall, 0);
        exp_stall += nbusy + 1;
    endtask

    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL decode_unexpected_accept got=%h exp=none at %0t", act(), $time);
            end else chk("decode", act(), exp_q.pop_front());
        end
        pend = rst_n && bus.instr_accept;
    end

    logic [31:0] t_ins [13] = '{32'h00010055, 32'h01020300, 32'h04010203, 32'h05030201, 32'h06100000,
                                32'h07000102, 32'h0C010203, 32'h0D010204, 32'h0E070605, 32'h0F050403,
                                32'hFF010203, 32'h08070707, 32'h02040102};
    logic [2:0]  t_alu [13] = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd0, 3'd1, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0, 3'd1};
    logic [9:0]  t_fl  [13] = '{10'b0110000000, 10'b0010000000, 10'b0010000000, 10'b0010000000,
                                10'b0001000000, 10'b1000100000, 10'b0110000000, 10'b0110001000,
                                10'b0110000000, 10'b0110000000, 10'b0000000000, 10'b0000000000,
                                10'b0010000000};
    logic        t_ill [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        z               = '0;
        rst_n           = 1'b0;
        bus.instruction = '0;
        bus.instr_valid = 1'b0;
        bus.busywait    = 1'b0;
        repeat (2) step();
        #1;
        chk("reset_outputs", act(), z);
        chk("reset_pcstall", bus.pc_stall, 0);
        rst_n = 1'b1;
        step();

        issue(32'h02040102, 3'd1, 10'b0010000000, 1'b0);
        issue(32'h03050607, 3'd1, 10'b1010000000, 1'b0);
        issue(32'h0BFE0102, 3'd1, 10'b1000010000, 1'b0);
        bus.instr_valid = 1'b0;
        step();
        #1;
        chk("idle_clear_ctrl", {act().alu, act().fl, act().ill}, 0);
        chk("idle_keep_dst", bus.destination, 6);
        chk("idle_keep_jmp", bus.jump_value, 8'hFE);

        drive(32'h13000001, 3'd0, 10'b0100000101, 1'b0);
        step();
        bus.instr_valid = 1'b0;
        bus.busywait    = 1'b1;
        step();
        #1 chk("pre_reset_memwrite", bus.mem_write, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", act(), z);
        chk("midreset_pcstall", bus.pc_stall, 0);
        step();
        rst_n        = 1'b1;
        bus.busywait = 1'b0;
        n_acc        = 0;
        exp_stall    = 0;
        step();

        issue_mem(32'h1103002A, 10'b0110000110, 3);

        issue(32'h09010203, 3'd0, 10'b0000000000, 1'b1);
        bus.instr_valid = 1'b0;
        step();
        #1 chk("illegal_one_cycle", bus.illegal, 0);

        for (int i = 0; i < 13; i++) issue(t_ins[i], t_alu[i], t_fl[i], t_ill[i]);
        bus.instr_valid = 1'b0;
        step();

        issue_mem(32'h10010203, 10'b0010000110, 0);
        issue_mem(32'h12040506, 10'b0000000101, 2);
        issue_mem(32'h1301020F, 10'b0100000101, 1);

        bus.instr_valid = 1'b0;
        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
`ifdef DECODE_PERF_EN
        chk("instr_count", instr_count, n_acc);
        chk("stall_count", stall_count, exp_stall);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/decode_control_seq.md
Name: decode_control_seq

Overview:
- Next-generation instruction decode and control unit for the single-cycle/multi-cycle processor.
- Registers all decoded fields and control signals, giving one cycle of latency. This isolates the instruction memory from the datapath.
- Adds an INSTR_VALID handshake, a stall state machine for data-memory BUSYWAIT, illegal-opcode detection, and parametrised field widths.
- Sits between the instruction memory/PC and the register file, ALU and data-memory interface.

Parameters:
- INSTR_W, 32, instruction width; must equal OPCODE_W + 3*FIELD_W.
- OPCODE_W, 8, opcode field width (bits [INSTR_W-1 -: OPCODE_W]).
- FIELD_W, 8, width of the DES, S1 and S2 fields and of the immediate/jump values.
- REG_ADDR_W, 3, register address width (low bits of each field).
- ALUOP_W, 3, ALU operation select width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INSTRUCTION  in  INSTR_W  fetched instruction {OPCODE, DES, S1, S2}.
- INSTR_VALID  in  1  INSTRUCTION is valid this cycle.
- BUSYWAIT  in  1  data memory busy.
- SOURCE1, SOURCE2, DESTINATION  out  REG_ADDR_W  register addresses.
- IMMEDIATEVALUE  out  FIELD_W  S2 field.
- JUMPVALUE  out  FIELD_W  DES field (jump/branch offset).
- ALUOP  out  ALUOP_W  ALU select.
- ISSUB, ISIMMEDIATE, WRITEENABLE, ISJUMP, ISBRANCH, ISBNE, ISSHIFTLEFT, ISMEM, MEMREAD, MEMWRITE  out  1  control signals.
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode.
- PCSTALL  out  1  PC/fetch must hold.
- INSTR_ACCEPT  out  1  combinational; INSTR_VALID is consumed this edge.

Behaviour:
- Reset (RESET=0, asynchronous):
  - All outputs are 0 and the state is IDLE.
  - A reset during MEM_WAIT drops MEMREAD/MEMWRITE immediately.
- States: IDLE, RUN, MEM_WAIT.
- IDLE:
  - INSTR_ACCEPT = INSTR_VALID.
  - On accept, go to RUN, or to MEM_WAIT if the opcode is LWD/LWI/SWD/SWI.
- RUN:
  - INSTR_ACCEPT = INSTR_VALID.
  - On accept, register the decoded outputs.
  - If no valid instruction arrives, go to IDLE and clear all control outputs to 0.
  - Field registers keep their values.
- MEM_WAIT:
  - Entered on the edge that registers a memory op; outputs are held and INSTR_ACCEPT = 0.
  - Stay while BUSYWAIT=1.
  - On the first edge with BUSYWAIT=0 (at least one cycle after entry): clear MEMREAD, MEMWRITE, ISMEM and WRITEENABLE, then go to IDLE.
- Accept edge with a non-memory op: outputs are valid on the next cycle (latency 1).
- PCSTALL = (state==MEM_WAIT) || (next state is MEM_WAIT). PCSTALL is 1 from the accept edge of a memory op through the completion edge.
- Opcode map (ALUOP/ISSUB/ISIMMEDIATE/WRITEENABLE plus any extra flags):
  - LOADI 0: 0/0/1/1
  - MOVE 1: 0/0/0/1
  - ADD 2: 1/0/0/1
  - SUB 3: 1/1/0/1
  - AND 4: 2/0/0/1
  - OR 5: 3/0/0/1
  - JUMP 6: ALUOP 0, ISJUMP=1, WRITEENABLE=0
  - BEQ 7: 1/1/0/0, ISBRANCH=1
  - BNE 11: 1/1/0/0, ISBNE=1
  - SRL 12: 5/0/1/1
  - SLL 13: 5/0/1/1, ISSHIFTLEFT=1
  - SRA 14: 6/0/1/1
  - ROR 15: 7/0/1/1
  - LWD 16: 0/0/0/1, ISMEM=1, MEMREAD=1
  - LWI 17: 0/0/1/1, ISMEM=1, MEMREAD=1
  - SWD 18: 0/0/0/0, ISMEM=1, MEMWRITE=1
  - SWI 19: 0/0/1/0, ISMEM=1, MEMWRITE=1
- Every flag not listed for an opcode is 0; no stale values carry over.
- Undefined opcode: all control outputs are 0 and ILLEGAL=1 for exactly one cycle. Fields are still registered and the state goes to RUN.
- Field extraction: register addresses are the low REG_ADDR_W bits of each field; IMMEDIATEVALUE and JUMPVALUE are the full field, zero-truncated.
- Simultaneous events:
  - BUSYWAIT=1 outside MEM_WAIT is ignored.
  - INSTR_VALID during MEM_WAIT is ignored; the PC holds it via PCSTALL.

Optional Feature:
- Macro: DECODE_PERF_EN.
- Defined: adds output INSTR_COUNT (16 bits) and output STALL_COUNT (16 bits).
  - INSTR_COUNT increments on every accept.
  - STALL_COUNT increments on every cycle spent in MEM_WAIT.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package decode_pkg holds:
  - the opcode localparams (LOADI..SWI);
  - the ALUOP encodings (ALU_FWD=0, ALU_ADD=1, ALU_AND=2, ALU_OR=3, ALU_SHL=5, ALU_SRA=6, ALU_ROR=7);
  - the state enum and a packed control-word typedef.
- Sub-module decode_control_lut: purely combinational, opcode -> control word plus illegal flag. The top holds the FSM and the output registers.

Test Plan:
- Reset with RESET=0 mid-stream -> all outputs 0, PCSTALL=0, state IDLE.
- Accept ADD 0x02_04_01_02 -> next cycle ALUOP=1, ISSUB=0, WRITEENABLE=1, DESTINATION=4, SOURCE1=1, SOURCE2=2.
- Accept SUB, then BNE 0x0B_FE_01_02 back-to-back -> ISSUB stays 1; BNE cycle has ISBNE=1, WRITEENABLE=0, JUMPVALUE=0xFE.
- Accept LWI 0x11_03_00_2A with BUSYWAIT=1 for 3 cycles:
  - MEMREAD=1, ISIMMEDIATE=1, IMMEDIATEVALUE=0x2A and PCSTALL=1 throughout;
  - INSTR_VALID ignored;
  - MEMREAD=0 one edge after BUSYWAIT falls.
- Opcode 0x09 -> ILLEGAL pulse of 1 cycle; all control outputs 0.
- With DECODE_PERF_EN: 5 instructions, one of them SWD with 2 busy cycles -> INSTR_COUNT=5, STALL_COUNT=2 or 3 depending on entry count. STALL_COUNT counts every cycle in MEM_WAIT, including the completion cycle: with 2 busy cycles the expected value is 3.
